regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port (writeEnable/dReg/wrData) between two

---
 rtl/regfile_wb_arbiter_if.sv | 50 +++++
 rtl/regfile_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: two producer slots, issue/scoreboard queries, regfile write port.
// The arbiter side uses the slave modport and the producers/regfile side uses the master modport.
interface regfile_wb_arbiter_if #(
    parameter int NREG = 16,
    parameter int DW   = 32
);
    localparam int IW = $clog2(NREG);

    logic          req0_valid;
    logic [IW-1:0] req0_dReg;
    logic [DW-1:0] req0_data;
    logic          req0_ready;

    logic          req1_valid;
    logic [IW-1:0] req1_dReg;
    logic [DW-1:0] req1_data;
    logic          req1_ready;

    logic          issue_valid;
    logic [IW-1:0] issue_dReg;
    logic [IW-1:0] src1_reg;
    logic [IW-1:0] src2_reg;
    logic          src1_busy;
    logic          src2_busy;

    logic          writeEnable;
    logic [IW-1:0] dReg;
    logic [DW-1:0] wrData;
    logic          prot_err;

    modport slave (
        input  req0_valid, req0_dReg, req0_data,
        output req0_ready,
        input  req1_valid, req1_dReg, req1_data,
        output req1_ready,
        input  issue_valid, issue_dReg, src1_reg, src2_reg,
        output src1_busy, src2_busy,
        output writeEnable, dReg, wrData, prot_err
    );

    modport master (
        output req0_valid, req0_dReg, req0_data,
        input  req0_ready,
        output req1_valid, req1_dReg, req1_data,
        input  req1_ready,
        output issue_valid, issue_dReg, src1_reg, src2_reg,
        input  src1_busy, src2_busy,
        input  writeEnable, dReg, wrData, prot_err
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU (slot0) and load (slot1) through 1-entry slots, plus a busy scoreboard.
// Latency: accept-to-writeEnable is 2 edges when uncontested. Backpressure: reqN_ready is !slotN full, with no ready-through.
// Round-robin arbitration is built when ARB_ROUND_ROBIN_EN is defined; otherwise the load slot has fixed priority.
module regfile_wb_arbiter #(
    parameter int NREG  = 16,
    parameter int DW    = 32,
    parameter int PROT0 = 14,
    parameter int PROT1 = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   bus
);
    localparam int IW = $clog2(NREG);
    localparam logic [IW-1:0] PROT0_IDX = IW'(PROT0);
    localparam logic [IW-1:0] PROT1_IDX = IW'(PROT1);

    logic          slot0_vld_q,  slot0_vld_d;
    logic [IW-1:0] slot0_dreg_q, slot0_dreg_d;
    logic [DW-1:0] slot0_dat_q,  slot0_dat_d;
    logic          slot1_vld_q,  slot1_vld_d;
    logic [IW-1:0] slot1_dreg_q, slot1_dreg_d;
    logic [DW-1:0] slot1_dat_q,  slot1_dat_d;

    logic [NREG-1:0] busy_q, busy_d;
    logic            we_q, we_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic [DW-1:0]   wr_dat_q, wr_dat_d;
    logic            prot_err_q, prot_err_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic            rr_ptr_q, rr_ptr_d;
`endif

    logic          grant0, grant1;
    logic          drain_vld;
    logic [IW-1:0] drain_dreg;
    logic [DW-1:0] drain_dat;
    logic          drain_prot;
    logic          issue_prot;

    function automatic logic is_prot(input logic [IW-1:0] r);
        return (r == PROT0_IDX) || (r == PROT1_IDX);
    endfunction

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_d = rr_ptr_q;
        if (slot0_vld_q && slot1_vld_q) begin
            grant0   = !rr_ptr_q;
            grant1   = rr_ptr_q;
            rr_ptr_d = !rr_ptr_q;
        end else begin
            grant0 = slot0_vld_q;
            grant1 = slot1_vld_q;
        end
`else
        grant1 = slot1_vld_q;
        grant0 = slot0_vld_q && !slot1_vld_q;
`endif
        drain_vld  = grant0 || grant1;
        drain_dreg = grant1 ? slot1_dreg_q : slot0_dreg_q;
        drain_dat  = grant1 ? slot1_dat_q  : slot0_dat_q;
        drain_prot = is_prot(drain_dreg);
        issue_prot = is_prot(bus.issue_dReg);
    end

    always_comb begin
        slot0_vld_d  = slot0_vld_q;
        slot0_dreg_d = slot0_dreg_q;
        slot0_dat_d  = slot0_dat_q;
        slot1_vld_d  = slot1_vld_q;
        slot1_dreg_d = slot1_dreg_q;
        slot1_dat_d  = slot1_dat_q;
        we_d         = 1'b0;
        wr_idx_d     = wr_idx_q;
        wr_dat_d     = wr_dat_q;
        prot_err_d   = prot_err_q;
        busy_d       = busy_q;

        // A full slot cannot accept, so the free-on-drain and capture paths never overlap.
        if (grant0) begin
            slot0_vld_d = 1'b0;
        end else if (bus.req0_valid && !slot0_vld_q) begin
            slot0_vld_d  = 1'b1;
            slot0_dreg_d = bus.req0_dReg;
            slot0_dat_d  = bus.req0_data;
        end

        if (grant1) begin
            slot1_vld_d = 1'b0;
        end else if (bus.req1_valid && !slot1_vld_q) begin
            slot1_vld_d  = 1'b1;
            slot1_dreg_d = bus.req1_dReg;
            slot1_dat_d  = bus.req1_data;
        end

        if (drain_vld) begin
            if (drain_prot) begin
                prot_err_d = 1'b1;
            end else begin
                we_d     = 1'b1;
                wr_idx_d = drain_dreg;
                wr_dat_d = drain_dat;
            end
            busy_d[drain_dreg] = 1'b0;
        end

        // Applied after the clear so a new producer issuing on the drain edge stays outstanding.
        if (bus.issue_valid && !issue_prot) begin
            busy_d[bus.issue_dReg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot0_vld_q  <= 1'b0;
            slot0_dreg_q <= '0;
            slot0_dat_q  <= '0;
            slot1_vld_q  <= 1'b0;
            slot1_dreg_q <= '0;
            slot1_dat_q  <= '0;
            busy_q       <= '0;
            we_q         <= 1'b0;
            wr_idx_q     <= '0;
            wr_dat_q     <= '0;
            prot_err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q     <= 1'b0;
`endif
        end else begin
            slot0_vld_q  <= slot0_vld_d;
            slot0_dreg_q <= slot0_dreg_d;
            slot0_dat_q  <= slot0_dat_d;
            slot1_vld_q  <= slot1_vld_d;
            slot1_dreg_q <= slot1_dreg_d;
            slot1_dat_q  <= slot1_dat_d;
            busy_q       <= busy_d;
            we_q         <= we_d;
            wr_idx_q     <= wr_idx_d;
            wr_dat_q     <= wr_dat_d;
            prot_err_q   <= prot_err_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign bus.req0_ready  = !slot0_vld_q;
    assign bus.req1_ready  = !slot1_vld_q;
    assign bus.src1_busy   = busy_q[bus.src1_reg];
    assign bus.src2_busy   = busy_q[bus.src2_reg];
    assign bus.writeEnable = we_q;
    assign bus.dReg        = wr_idx_q;
    assign bus.wrData      = wr_dat_q;
    assign bus.prot_err    = prot_err_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a write scoreboard is filled as requests are driven and drained on writeEnable.
module tb_regfile_wb_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [35:0] exp_q[$];

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.writeEnable === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0)
            else begin
                errors++;
                $error("FAIL unexpected_write observed=dReg %0d data 0x%0h expected=no write", bus.dReg, bus.wrData);
            end
            if (exp_q.size() != 0) begin
                logic [35:0] e;
                e = exp_q.pop_front();
                chk("wr_dreg", 32'(bus.dReg), 32'(e[35:32]));
                chk("wr_data", bus.wrData, e[31:0]);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_dReg = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_dReg = '0; bus.req1_data = '0;
        bus.issue_valid = 1'b0; bus.issue_dReg = '0;
        bus.src1_reg = '0; bus.src2_reg = '0;

        // reset state
        tick(); tick();
        reset = 1'b1;
        chk("rst_we", 32'(bus.writeEnable), 32'd0);
        chk("rst_dreg", 32'(bus.dReg), 32'd0);
        chk("rst_wrdata", bus.wrData, 32'd0);
        chk("rst_prot_err", 32'(bus.prot_err), 32'd0);
        chk("rst_ready0", 32'(bus.req0_ready), 32'd1);
        chk("rst_ready1", 32'(bus.req1_ready), 32'd1);
        for (int r = 0; r < 16; r++) begin
            bus.src1_reg = 4'(r);
            #1;
            chk("rst_busy", 32'(bus.src1_busy), 32'd0);
        end

        // single ALU write, 2-edge latency
        bus.req0_valid = 1'b1; bus.req0_dReg = 4'd3; bus.req0_data = 32'hDEADBEEF;
        exp_q.push_back({4'd3, 32'hDEADBEEF});
        tick();
        bus.req0_valid = 1'b0;
        chk("t2_ready0_full", 32'(bus.req0_ready), 32'd0);
        chk("t2_we_early", 32'(bus.writeEnable), 32'd0);
        tick();
        chk("t2_we", 32'(bus.writeEnable), 32'd1);
        chk("t2_ready0_free", 32'(bus.req0_ready), 32'd1);
        tick();
        chk("t2_we_pulse", 32'(bus.writeEnable), 32'd0);

        // both slots accepted on the same edge
        bus.req0_valid = 1'b1; bus.req0_dReg = 4'd5; bus.req0_data = 32'h11;
        bus.req1_valid = 1'b1; bus.req1_dReg = 4'd6; bus.req1_data = 32'h22;
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back({4'd5, 32'h11});
        exp_q.push_back({4'd6, 32'h22});
`else
        exp_q.push_back({4'd6, 32'h22});
        exp_q.push_back({4'd5, 32'h11});
`endif
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("t3_ready0_full", 32'(bus.req0_ready), 32'd0);
        chk("t3_ready1_full", 32'(bus.req1_ready), 32'd0);
        tick();
`ifdef ARB_ROUND_ROBIN_EN
        chk("t3_first_freed", 32'({bus.req1_ready, bus.req0_ready}), 32'b01);
`else
        chk("t3_first_freed", 32'({bus.req1_ready, bus.req0_ready}), 32'b10);
`endif
        tick(); tick();
        chk("t3_drained", 32'({bus.req1_ready, bus.req0_ready}), 32'b11);

        // scoreboard set, clear, and set-wins on the drain edge
        bus.issue_valid = 1'b1; bus.issue_dReg = 4'd7;
        bus.src1_reg = 4'd7; bus.src2_reg = 4'd7;
        #1;
        chk("t4_no_bypass", 32'(bus.src1_busy), 32'd0);
        tick();
        bus.issue_valid = 1'b0;
        chk("t4_busy1", 32'(bus.src1_busy), 32'd1);
        chk("t4_busy2", 32'(bus.src2_busy), 32'd1);
        bus.req1_valid = 1'b1; bus.req1_dReg = 4'd7; bus.req1_data = 32'h77;
        exp_q.push_back({4'd7, 32'h77});
        tick();
        bus.req1_valid = 1'b0;
        chk("t4_busy_pending", 32'(bus.src1_busy), 32'd1);
        tick();
        chk("t4_cleared", 32'(bus.src1_busy), 32'd0);
        bus.issue_valid = 1'b1; bus.issue_dReg = 4'd7;
        tick();
        bus.issue_valid = 1'b0;
        chk("t4_reissue", 32'(bus.src1_busy), 32'd1);
        bus.req1_valid = 1'b1; bus.req1_dReg = 4'd7; bus.req1_data = 32'h78;
        exp_q.push_back({4'd7, 32'h78});
        tick();
        bus.req1_valid = 1'b0;
        bus.issue_valid = 1'b1; bus.issue_dReg = 4'd7;
        tick();
        bus.issue_valid = 1'b0;
        chk("t4_set_wins", 32'(bus.src1_busy), 32'd1);
        tick();

        // protected targets
        bus.req0_valid = 1'b1; bus.req0_dReg = 4'd14; bus.req0_data = 32'h55;
        tick();
        bus.req0_valid = 1'b0;
        chk("t5_prot_before", 32'(bus.prot_err), 32'd0);
        tick();
        chk("t5_prot_set", 32'(bus.prot_err), 32'd1);
        chk("t5_prot_no_we", 32'(bus.writeEnable), 32'd0);
        chk("t5_slot_freed", 32'(bus.req0_ready), 32'd1);
        bus.issue_valid = 1'b1; bus.issue_dReg = 4'd15; bus.src2_reg = 4'd15;
        tick();
        bus.issue_valid = 1'b0;
        chk("t5_busy15", 32'(bus.src2_busy), 32'd0);
        tick(); tick(); tick();
        chk("t5_prot_sticky", 32'(bus.prot_err), 32'd1);

        // reset mid-operation
        bus.src1_reg = 4'd2; bus.src2_reg = 4'd7;
        bus.issue_valid = 1'b1; bus.issue_dReg = 4'd2;
        tick();
        bus.issue_valid = 1'b0;
        chk("t6_busy2_set", 32'(bus.src1_busy), 32'd1);
        bus.req0_valid = 1'b1; bus.req0_dReg = 4'd8; bus.req0_data = 32'h88;
        bus.req1_valid = 1'b1; bus.req1_dReg = 4'd9; bus.req1_data = 32'h99;
        tick();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        chk("t6_full", 32'({bus.req1_ready, bus.req0_ready}), 32'b00);
        reset = 1'b0;
        tick();
        chk("t6_we", 32'(bus.writeEnable), 32'd0);
        chk("t6_empty", 32'({bus.req1_ready, bus.req0_ready}), 32'b11);
        chk("t6_busy2", 32'(bus.src1_busy), 32'd0);
        chk("t6_busy7", 32'(bus.src2_busy), 32'd0);
        chk("t6_prot_clr", 32'(bus.prot_err), 32'd0);
        reset = 1'b1;
        tick(); tick(); tick();
        chk("t6_we_after", 32'(bus.writeEnable), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
